commonlib_rrmuxn: RTL and testbench
===================================

COMMONLIB_RRMUXN -- requirements
Module: commonlib_rrmuxn

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning number of requester ports (legal range 1..16).
REQ-002 The block SHALL have parameter width, default 32, meaning data bits per requester.
REQ-003 The block SHALL use derived constant SELW = max(1, ceil(log2(N))), matching the select width of the downstream N-way mux.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, named as in the codebase. The ports are:
- clk  input  1  rising-edge clock
- arst  input  1  asynchronous active-high reset
- in_valid  input  N  per-requester data valid
- in_data  input  width x N (unpacked array [N-1:0])  per-requester data
- in_ready  output  N  per-requester accept, one-hot or zero
- out_valid  output  1  registered output holds a word
- out_ready  input  1  downstream accepts the word
- out_data  output  width  registered selected word
- out_sel  output  SELW  index of the requester that produced out_data

Function
REQ-005 The block SHALL grant at most one requester per cycle: the first i with in_valid[i]=1 when searching from (ptr+1) mod N upward, wrapping modulo N.
REQ-006 The load condition SHALL be load = (!out_valid || out_ready) && any(in_valid).
REQ-007 in_ready[g] SHALL be 1 only for granted index g and only when load=1; all other bits SHALL be 0. in_ready SHALL be combinational from in_valid, ptr, out_valid and out_ready.
REQ-008 On a clock edge with load=1, the block SHALL set out_data <= in_data[g], out_sel <= g, out_valid <= 1 and ptr <= g. Latency from accept to out_valid is 1 cycle.
REQ-009 On a clock edge with out_valid && out_ready && !any(in_valid), the block SHALL set out_valid <= 0; out_data and out_sel SHALL hold their values.
REQ-010 While out_valid && !out_ready, out_data, out_sel, out_valid and ptr SHALL hold stable and in_ready SHALL be all-zero.
REQ-011 A simultaneous drain and load SHALL proceed with no bubble, sustaining 1 word per cycle.
REQ-012 ptr SHALL change only on an accept; idle cycles SHALL NOT advance it.
REQ-013 With N=1, the block SHALL grant requester 0 whenever it is valid, and out_sel SHALL be constant 0.
REQ-014 Grant fairness: a continuously valid requester SHALL be granted within N accepts.
REQ-015 Selection arithmetic SHALL be modulo N, not modulo 2^SELW, for non-power-of-two N. Example: N=5, ptr=4 wraps the search to 0.
REQ-016 The block SHALL contain no combinational path from out_ready to out_data or out_valid.

Reset
REQ-017 While arst=1, and immediately on its assertion: out_valid=0, out_data=0, out_sel=0, ptr=N-1 (first search starts at index 0).
REQ-018 in_ready SHALL be 0 while arst=1.
REQ-019 A word held in the output register when arst asserts SHALL be discarded, and no requester SHALL see in_ready on the reset cycle.
REQ-020 After arst deasserts, the first accept SHALL occur on the first rising edge at which the load condition holds.

Structure
REQ-021 The shared package SHALL hold the function computing SELW from N and the modulo-N increment function.
REQ-022 The round-robin search SHALL be one sub-module, commonlib_rrgrant (inputs: valid vector, ptr; outputs: one-hot grant, encoded index, any).
REQ-023 The data selection SHALL use an instance of the existing N-way mux, with select = encoded grant index.
REQ-024 Total RTL SHALL be 120-400 lines.

Verification
REQ-025 Scenario 1: release arst; in_valid=5'b00101, out_ready=1, in_data[i]=i+100 -> accepts index 0 then 2 then 0; out_sel 0,2,0 on consecutive cycles; out_data 100,102,100.
REQ-026 Scenario 2: all 5 valid, out_ready=1 for 10 cycles -> out_sel 0,1,2,3,4,0,1,2,3,4; out_valid continuously 1 from cycle 1.
REQ-027 Scenario 3: out_ready=0 with out_valid=1 (out_sel=3) for 4 cycles while in_valid=5'b11111 -> in_ready=0, out_data/out_sel stable; out_ready=1 then yields out_sel=4 next.
REQ-028 Scenario 4: single valid requester 4, ptr=4 -> wraps correctly, index 4 granted again, out_sel=4.
REQ-029 Scenario 5: assert arst mid-stall with out_valid=1 -> out_valid=0, out_data=0 asynchronously; after release, the first grant goes to the lowest valid index.
REQ-030 Scenario 6: N=1, width=8, in_valid toggling, out_ready random -> every valid word delivered once, in order, out_sel=0.

Source files
------------

// File: rtl/commonlib_rrmuxn_pkg.sv
// Shared helpers for the round-robin N-to-1 register mux: select-width
// derivation and modulo-N index increment.
package commonlib_rrmuxn_pkg;

   localparam int MAX_N = 16;

   // Select width of an N-way mux, never below one bit.
   function automatic int selw_f(input int n);
      if (n <= 32'sd2) begin
         return 32'sd1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Next requester index, wrapping at N rather than at a power of two.
   function automatic int mod_inc(input int v, input int n);
      if ((v + 32'sd1) >= n) begin
         return 32'sd0;
      end else begin
         return v + 32'sd1;
      end
   endfunction

endpackage

// File: rtl/commonlib_muxn.sv
// Plain N-way data mux; out-of-range selects yield zero.
module commonlib_muxn #(
   parameter int N     = 5,
   parameter int width = 32,
   parameter int SELW  = 3
) (
   input  logic [SELW-1:0]  sel,
   input  logic [width-1:0] din [N-1:0],
   output logic [width-1:0] dout
);

   // AND-OR select keeps the mux free of dynamic array indexing.
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         dout = dout | ((sel == SELW'(i)) ? din[i] : '0);
      end
   end

endmodule

// File: rtl/commonlib_rrgrant.sv
// Round-robin search: first valid index after ptr, wrapping modulo N.
module commonlib_rrgrant
   import commonlib_rrmuxn_pkg::*;
#(
   parameter int N    = 5,
   parameter int SELW = selw_f(N)
) (
   input  logic [N-1:0]    valid,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] idx,
   output logic            any
);

   // Walk the N candidates in priority order; the first valid hit wins.
   always_comb begin
      int   cand;
      logic found;
      logic hit;
      grant = '0;
      idx   = '0;
      any   = |valid;
      found = 1'b0;
      hit   = 1'b0;
      cand  = int'(ptr);
      for (int k = 0; k < N; k++) begin
         cand = mod_inc(cand, N);
         for (int i = 0; i < N; i++) begin
            hit      = !found && (cand == i) && valid[i];
            grant[i] = grant[i] | hit;
            found    = found | hit;
         end
      end
      for (int i = 0; i < N; i++) begin
         idx = idx | (grant[i] ? SELW'(i) : '0);
      end
   end

endmodule

// File: rtl/commonlib_rrmuxn.sv
// Round-robin N-to-1 arbiter feeding a single registered output slot
// with valid/ready handshakes on both sides.
module commonlib_rrmuxn
   import commonlib_rrmuxn_pkg::*;
#(
   parameter int N     = 5,
   parameter int width = 32,
   localparam int SELW = selw_f(N)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [N-1:0]     in_valid,
   input  logic [width-1:0] in_data [N-1:0],
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data,
   output logic [SELW-1:0]  out_sel
);

   logic [SELW-1:0]  ptr_r;
   logic [N-1:0]     grant_s;
   logic [SELW-1:0]  gidx_s;
   logic             any_s;
   logic             load_s;
   logic [width-1:0] mux_s;

   commonlib_rrgrant #(.N(N), .SELW(SELW)) u_grant (
      .valid (in_valid),
      .ptr   (ptr_r),
      .grant (grant_s),
      .idx   (gidx_s),
      .any   (any_s)
   );

   commonlib_muxn #(.N(N), .width(width), .SELW(SELW)) u_mux (
      .sel  (gidx_s),
      .din  (in_data),
      .dout (mux_s)
   );

   // Accept when the slot is empty or draining; nobody is acked during reset.
   always_comb begin
      load_s = (!out_valid || out_ready) && any_s;
      if (arst) begin
         in_ready = '0;
      end else if (load_s) begin
         in_ready = grant_s;
      end else begin
         in_ready = '0;
      end
   end

   // Output slot and round-robin pointer; ptr moves only on an accept.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr_r     <= SELW'(N - 1);
      end else if (load_s) begin
         out_valid <= 1'b1;
         out_data  <= mux_s;
         out_sel   <= gidx_s;
         ptr_r     <= gidx_s;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: tb/tb_commonlib_rrmuxn.sv
// Scoreboard bench: expected words queued at stimulus time, popped by
// negedge monitors on every output handshake.
module tb_commonlib_rrmuxn;

   typedef struct packed {
      logic [2:0]  sel;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   // N=5, width=32 instance
   logic [4:0]  in_valid = '0;
   logic [31:0] in_data [4:0];
   logic [4:0]  in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_sel;
   // N=1, width=8 instance
   logic [0:0]  v1 = '0;
   logic [7:0]  d1 [0:0];
   logic [0:0]  ir1;
   logic        ov1;
   logic        r1 = 1'b0;
   logic [7:0]  od1;
   logic [0:0]  os1;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t       q5[$];
   logic [7:0] q1[$];

   always #5 clk = ~clk;

   commonlib_rrmuxn #(.N(5), .width(32)) dut5 (
      .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel)
   );

   commonlib_rrmuxn #(.N(1), .width(8)) dut1 (
      .clk(clk), .arst(arst), .in_valid(v1), .in_data(d1),
      .in_ready(ir1), .out_valid(ov1), .out_ready(r1),
      .out_data(od1), .out_sel(os1)
   );

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push5(input int s);
      exp_t e;
      e.sel  = 3'(s);
      e.data = 32'(100 + s);
      q5.push_back(e);
   endtask

   task automatic do_reset();
      step();
      arst     = 1'b1;
      in_valid = 5'b00000;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      step();
      arst = 1'b0;
   endtask

   // Monitor for the 5-way instance.
   always @(negedge clk) begin
      exp_t e;
      if (!arst && out_valid && out_ready) begin
         if (q5.size() == 0) begin
            check("mon5_unexpected", {29'd0, out_sel, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = q5.pop_front();
            check("mon5_word", {29'd0, out_sel, out_data}, {29'd0, e.sel, e.data});
         end
      end
   end

   // Monitor and input-side scoreboard for the single-requester instance.
   always @(negedge clk) begin
      logic [7:0] e1;
      if (!arst) begin
         if (ov1 && r1) begin
            if (q1.size() == 0) begin
               check("mon1_unexpected", {55'd0, os1, od1}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e1 = q1.pop_front();
               check("mon1_word", {55'd0, os1, od1}, {56'd0, e1});
            end
         end
         if (v1[0] && ir1[0]) begin
            q1.push_back(d1[0]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 5; i++) in_data[i] = 32'(100 + i);
      d1[0] = 8'd0;
      #2;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_out_sel", 64'(out_sel), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      step();
      arst = 1'b0;

      // Scenario 1: requesters 0 and 2 alternate.
      in_valid  = 5'b00101;
      out_ready = 1'b1;
      push5(0); push5(2); push5(0);
      #1;
      check("s1_first_ready", 64'(in_ready), 64'd1);
      step(); check("s1_sel0", 64'(out_sel), 64'd0);
      step(); check("s1_sel1", 64'(out_sel), 64'd2);
      step(); check("s1_sel2", 64'(out_sel), 64'd0);
      in_valid = 5'b00000;
      step();
      check("s1_drained", 64'(out_valid), 64'd0);
      check("s1_sel_hold", 64'(out_sel), 64'd0);

      // Scenario 2: all valid, full rotation without bubbles.
      do_reset();
      in_valid  = 5'b11111;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) push5(k % 5);
      for (int k = 0; k < 10; k++) begin
         step();
         check("s2_valid", 64'(out_valid), 64'd1);
         check("s2_sel", 64'(out_sel), 64'(k % 5));
      end
      in_valid = 5'b00000;
      step();

      // Scenario 3: stall holding word 3, then resume with 4.
      do_reset();
      in_valid  = 5'b11111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) push5(k);
      for (int k = 0; k < 4; k++) step();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("s3_ready_zero", 64'(in_ready), 64'd0);
         check("s3_hold", {29'd0, out_valid, out_sel, out_data}, {29'd0, 1'b1, 3'd3, 32'd103});
      end
      out_ready = 1'b1;
      step();
      check("s3_next_sel", 64'(out_sel), 64'd4);
      in_valid = 5'b00000;
      step();

      // Scenario 4: ptr=4 with only requester 4 valid wraps back to 4.
      in_valid = 5'b10000;
      push5(4); push5(4);
      #1;
      check("s4_ready", 64'(in_ready), 64'h10);
      step(); check("s4_sel_a", 64'(out_sel), 64'd4);
      step(); check("s4_sel_b", 64'(out_sel), 64'd4);
      in_valid = 5'b00000;
      step();

      // Scenario 5: reset in the middle of a stall discards the word.
      in_valid  = 5'b11111;
      out_ready = 1'b0;
      step();
      check("s5_loaded", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'd100});
      step();
      #2;
      arst = 1'b1;
      #1;
      check("s5_async_valid", 64'(out_valid), 64'd0);
      check("s5_async_data", 64'(out_data), 64'd0);
      check("s5_async_sel", 64'(out_sel), 64'd0);
      check("s5_async_ready", 64'(in_ready), 64'd0);
      step();
      check("s5_rst_edge_valid", 64'(out_valid), 64'd0);
      arst      = 1'b0;
      in_valid  = 5'b01010;
      out_ready = 1'b1;
      push5(1);
      step();
      check("s5_first_grant", 64'(out_sel), 64'd1);
      in_valid = 5'b00000;
      step();

      // Scenario 6: single requester, random toggling on both sides.
      for (int k = 0; k < 60; k++) begin
         v1[0] = 1'($urandom_range(0, 1));
         r1    = 1'($urandom_range(0, 1));
         d1[0] = 8'(k + 8'd1);
         step();
         if (ov1) check("s6_sel", 64'(os1), 64'd0);
      end
      v1[0] = 1'b0;
      r1    = 1'b1;
      for (int k = 0; k < 20 && (q1.size() != 0 || ov1); k++) step();

      step();
      check("end_q5_empty", 64'(q5.size()), 64'd0);
      check("end_q1_empty", 64'(q1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
